// File: rtl/fir_tap_loader.sv
// Streams N coefficient words from a valid/ready source into the FIR tap RAM
// write port and holds the FIR datapath frozen until a complete tap set is present.
module fir_tap_loader #(
    parameter int N      = 11,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              coef_valid,
    input  logic [WIDTH-1:0]  coef_data,
    output logic              coef_ready,
    output logic [WIDTH-1:0]  tap_ram_in,
    output logic [3:0]        tap_ram_we,
    output logic [ADDR_W-1:0] tap_ram_addr,
    output logic              fir_hold,
    output logic              taps_valid,
    output logic              load_done,
    output logic              overrun_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic              handshake;
    logic              last_tap;

    assign coef_ready = (state == LOAD);
    // load_start wins over a coincident handshake: that word is dropped.
    assign handshake  = coef_valid & coef_ready & ~load_start;
    assign last_tap   = (idx == LAST_IDX);
    assign fir_hold   = ~taps_valid;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (load_start) begin
            state_nxt = LOAD;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                LOAD: begin
                    if (handshake) begin
                        if (last_tap) begin
                            state_nxt = DONE;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + ADDR_W'(1);
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_ram_we   <= 4'h0;
            tap_ram_addr <= '0;
            tap_ram_in   <= '0;
            taps_valid   <= 1'b0;
            load_done    <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            tap_ram_we <= handshake ? 4'hF : 4'h0;
            if (handshake) begin
                tap_ram_addr <= idx;
                tap_ram_in   <= coef_data;
            end
            load_done <= (state == DONE) & ~load_start;
            if (load_start) begin
                taps_valid  <= 1'b0;
                overrun_err <= 1'b0;
            end else begin
                if (state == DONE)
                    taps_valid <= 1'b1;
                if (coef_valid && (state != LOAD))
                    overrun_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Self-checking bench for fir_tap_loader: write-port monitor, shadow tap RAM and
// a behavioural FIR used to check the loaded tap set.
module tb_fir_tap_loader;
    localparam int N      = 11;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              coef_valid;
    logic [WIDTH-1:0]  coef_data;
    logic              coef_ready;
    logic [WIDTH-1:0]  tap_ram_in;
    logic [3:0]        tap_ram_we;
    logic [ADDR_W-1:0] tap_ram_addr;
    logic              fir_hold;
    logic              taps_valid;
    logic              load_done;
    logic              overrun_err;

    fir_tap_loader #(.N(N), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .coef_valid(coef_valid),
        .coef_data(coef_data), .coef_ready(coef_ready), .tap_ram_in(tap_ram_in),
        .tap_ram_we(tap_ram_we), .tap_ram_addr(tap_ram_addr), .fir_hold(fir_hold),
        .taps_valid(taps_valid), .load_done(load_done), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int               obs_addr[$];
    logic [WIDTH-1:0] obs_data[$];
    int               done_pulses = 0;
    int               done_cyc    = -1;
    int               bad_we      = 0;
    int               hold_viol   = 0;
    logic [WIDTH-1:0] ram [N];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tap_ram_we !== 4'h0) begin
            obs_addr.push_back(int'(tap_ram_addr));
            obs_data.push_back(tap_ram_in);
            if (tap_ram_we !== 4'hF) bad_we++;
            if (fir_hold !== 1'b1) hold_viol++;
            if (int'(tap_ram_addr) < N) ram[int'(tap_ram_addr)] = tap_ram_in;
        end
        if (load_done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc;
        end
    end

    task automatic clear_obs();
        @(posedge clk);
        #1;
        obs_addr.delete();
        obs_data.delete();
        done_pulses = 0;
        done_cyc    = -1;
        bad_we      = 0;
        hold_viol   = 0;
    endtask

    task automatic do_load_start();
        @(negedge clk);
        load_start = 1'b1;
        coef_valid = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid low every other cycle, 2: random gaps
    task automatic send_words(input logic [WIDTH-1:0] w[$], input int mode, output int last_hs);
        int i = 0;
        int slot = 0;
        last_hs = -1;
        while (i < w.size() && slot < 400) begin
            @(negedge clk);
            if ((mode == 1 && slot % 2 == 1) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                coef_valid = 1'b0;
            end else begin
                coef_valid = 1'b1;
                coef_data  = w[i];
            end
            if (coef_valid && coef_ready) begin
                i++;
                last_hs = cyc;
            end
            slot++;
        end
        n_checks++;
        if (i != w.size()) begin
            n_fail++;
            $display("FAIL send_timeout: sent %0d words, required %0d", i, w.size());
        end
        @(negedge clk);
        coef_valid = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] base_tap(input int k);
        return WIDTH'((k <= 5) ? k + 1 : 11 - k);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({coef_ready, tap_ram_we, taps_valid, fir_hold, load_done, overrun_err} !== 9'b0_0000_0100 ||
            tap_ram_addr !== '0 || tap_ram_in !== '0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%0d in=%0h tv=%b hold=%b done=%b ovr=%b, required 0 0 0 0 0 1 0 0",
                     coef_ready, tap_ram_we, tap_ram_addr, tap_ram_in, taps_valid, fir_hold, load_done, overrun_err);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (coef_ready !== 1'b0 || taps_valid !== 1'b0 || fir_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: rdy=%b tv=%b hold=%b, required 0 0 1", coef_ready, taps_valid, fir_hold);
        end
    endtask

    // Compares the observed write sequence against the expected queues.
    task automatic check_load(input string name, input int exp_addr[$], input logic [WIDTH-1:0] exp_data[$],
                              input int last_hs);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d writes, required %0d", name, obs_addr.size(), exp_addr.size());
        end
        for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
            n_checks++;
            if (obs_addr[k] != exp_addr[k] || obs_data[k] !== exp_data[k]) begin
                n_fail++;
                $display("FAIL %s_write%0d: addr=%0d data=%0h, required addr=%0d data=%0h",
                         name, k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
            end
        end
        n_checks++;
        if (done_pulses != 1 || done_cyc != last_hs + 2) begin
            n_fail++;
            $display("FAIL %s_load_done: pulses=%0d at cyc %0d, required 1 at cyc %0d", name, done_pulses, done_cyc, last_hs + 2);
        end
        n_checks++;
        if (taps_valid !== 1'b1 || fir_hold !== 1'b0 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_final: tv=%b hold=%b done=%b, required 1 0 0", name, taps_valid, fir_hold, load_done);
        end
        n_checks++;
        if (bad_we != 0 || hold_viol != 0) begin
            n_fail++;
            $display("FAIL %s_we_hold: bad_we=%0d hold_viol=%0d, required 0 0", name, bad_we, hold_viol);
        end
    endtask

    task automatic test_basic_load(input int mode, input string name);
        logic [WIDTH-1:0] w[$];
        int ea[$];
        int hs;
        for (int k = 0; k < N; k++) begin
            w.push_back(base_tap(k));
            ea.push_back(k);
        end
        clear_obs();
        do_load_start();
        n_checks++;
        if (coef_ready !== 1'b1 || taps_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_loading: rdy=%b tv=%b, required 1 0", name, coef_ready, taps_valid);
        end
        send_words(w, mode, hs);
        check_load(name, ea, w, hs);
    endtask

    task automatic test_fir_run();
        int x[$];
        int hist[N];
        longint y_dut, y_ref;
        for (int v = 0; v <= 20; v++) x.push_back(v);
        for (int v = 19; v >= 0; v--) x.push_back(v);
        for (int k = 0; k < N; k++) hist[k] = 0;
        for (int n = 0; n < x.size() + N - 1; n++) begin
            @(negedge clk);
            for (int k = N - 1; k > 0; k--) hist[k] = hist[k - 1];
            hist[0] = (n < x.size()) ? x[n] : 0;
            y_dut = 0;
            for (int k = 0; k < N; k++) y_dut += longint'($signed(ram[k])) * hist[k];
            y_ref = 0;
            for (int k = 0; k < N; k++)
                if (n - k >= 0 && n - k < x.size()) y_ref += longint'((k <= 5) ? k + 1 : 11 - k) * x[n - k];
            n_checks++;
            if (fir_hold !== 1'b0 || y_dut != y_ref) begin
                n_fail++;
                $display("FIR_OUT FAIL fir_y%0d: y=%0d hold=%b, required y=%0d hold=0", n, y_dut, fir_hold, y_ref);
            end
        end
    endtask

    task automatic test_restart();
        logic [WIDTH-1:0] w1[$];
        logic [WIDTH-1:0] w2[$];
        logic [WIDTH-1:0] ed[$];
        int ea[$];
        int hs;
        for (int k = 0; k < 5; k++) begin
            w1.push_back(base_tap(k));
            ea.push_back(k);
            ed.push_back(base_tap(k));
        end
        for (int k = 0; k < N; k++) begin
            w2.push_back(WIDTH'(10 + k));
            ea.push_back(k);
            ed.push_back(WIDTH'(10 + k));
        end
        clear_obs();
        do_load_start();
        send_words(w1, 0, hs);
        @(negedge clk);
        coef_valid = 1'b1;
        coef_data  = 32'hDEAD_BEEF;
        load_start = 1'b1;
        @(negedge clk);
        coef_valid = 1'b0;
        load_start = 1'b0;
        send_words(w2, 0, hs);
        check_load("restart", ea, ed, hs);
    endtask

    task automatic test_overrun();
        logic [WIDTH-1:0] w[$];
        int ea[$];
        int hs;
        clear_obs();
        @(negedge clk);
        coef_valid = 1'b1;
        coef_data  = $urandom;
        @(negedge clk);
        coef_valid = 1'b0;
        n_checks++;
        if (overrun_err !== 1'b1 || taps_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b tv=%b, required 1 1", overrun_err, taps_valid);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (overrun_err !== 1'b1 || obs_addr.size() != 0) begin
            n_fail++;
            $display("FAIL overrun_sticky: ovr=%b writes=%0d, required 1 0", overrun_err, obs_addr.size());
        end
        do_load_start();
        n_checks++;
        if (overrun_err !== 1'b0 || taps_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b tv=%b, required 0 0", overrun_err, taps_valid);
        end
        for (int k = 0; k < N; k++) begin
            w.push_back($urandom);
            ea.push_back(k);
        end
        send_words(w, 0, hs);
        check_load("post_overrun", ea, w, hs);
    endtask

    task automatic test_reset_mid_load();
        logic [WIDTH-1:0] w[$];
        int ea[$];
        int hs;
        for (int k = 0; k < 7; k++) w.push_back($urandom);
        do_load_start();
        send_words(w, 0, hs);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (taps_valid !== 1'b0 || fir_hold !== 1'b1 || tap_ram_we !== 4'h0 || coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load: tv=%b hold=%b we=%b rdy=%b, required 0 1 0000 0",
                     taps_valid, fir_hold, tap_ram_we, coef_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        w.delete();
        for (int k = 0; k < N; k++) begin
            w.push_back($urandom);
            ea.push_back(k);
        end
        clear_obs();
        do_load_start();
        send_words(w, 0, hs);
        check_load("reload", ea, w, hs);
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 3; it++) begin
            logic [WIDTH-1:0] w[$];
            int ea[$];
            int hs;
            for (int k = 0; k < N; k++) begin
                w.push_back($urandom);
                ea.push_back(k);
            end
            clear_obs();
            do_load_start();
            send_words(w, 2, hs);
            check_load("random", ea, w, hs);
        end
    endtask

    initial begin
        load_start = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        for (int k = 0; k < N; k++) ram[k] = '0;
        test_reset();
        test_basic_load(0, "basic");
        test_fir_run();
        test_basic_load(1, "gaps");
        test_overrun();
        test_restart();
        test_reset_mid_load();
        test_random_loads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
